// File: rtl/puf_kline_eval.sv
// K-line, N-stage multiplexer-permutation PUF with an evaluation controller.
// Each challenge is evaluated NEVAL times and each line is majority-voted.

module puf_kline_stage #(
  parameter int K = 4,
  parameter int S = 0
) (
  input  logic [K-1:0] din,
  input  logic         sel,
  output logic [K-1:0] dout
);

  // Both index maps are bijections when K is a power of two.
  for (genvar i = 0; i < K; i++) begin : g_line
    localparam int IA = (3 * i + S) % K;
    localparam int IB = (5 * i + S + 1) % K;
    assign dout[i] = sel ? din[IB] : din[IA];
  end

endmodule

module puf_kline_eval #(
  parameter int K          = 4,
  parameter int N          = 64,
  parameter int NEVAL      = 3,
  parameter int RST_CYC    = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         ivalid,
  output logic         ordy,
  input  logic [N-1:0] iC,
  input  logic         imode,
  input  logic [K-1:0] ipattern,
  output logic         ovalid,
  input  logic         iresp_ready,
  output logic [K-1:0] oresp,
  output logic [K-1:0] ounstable,
  output logic         obusy
);

  localparam int CW   = $clog2(NEVAL + 1);
  localparam int MAXC = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] NEV      = CW'(NEVAL);
  localparam logic [CW-1:0] HALF     = CW'(NEVAL / 2);
  localparam logic [CW-1:0] ELAST    = CW'(NEVAL - 1);
  localparam logic [PW-1:0] DIS_LAST = PW'(RST_CYC - 1);
  localparam logic [PW-1:0] CHG_LAST = PW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    DISCH,
    CHARGE,
    SAMPLE,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [CW-1:0] ecnt;
  logic [CW-1:0] cnt     [K];
  logic [CW-1:0] cnt_nxt [K];
  logic [N-1:0]  c_q;
  logic          mode_q;
  logic [K-1:0]  pat_q;
  logic          trig;
  logic [K-1:0]  resp_nxt;
  logic [K-1:0]  unst_nxt;

  logic [K-1:0]  launch;
  logic [K-1:0]  net [N+1];
  logic [K-1:0]  line;

  // Delay network: one stage instance per challenge bit, kept as hierarchy.
  assign launch = mode_q ? (pat_q & {K{trig}}) : {K{trig}};
  assign net[0] = launch;

  for (genvar s = 0; s < N; s++) begin : g_stage
    puf_kline_stage #(
      .K(K),
      .S(s)
    ) u_stage (
      .din (net[s]),
      .sel (c_q[s]),
      .dout(net[s+1])
    );
  end

  assign line = net[N];

  assign ordy  = (state == IDLE) && !irst;
  assign obusy = (state != IDLE);

  // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
  always_comb begin
    for (int j = 0; j < K; j++) begin
      cnt_nxt[j]  = cnt[j] + CW'(line[j]);
      resp_nxt[j] = (cnt_nxt[j] > HALF);
      unst_nxt[j] = (cnt_nxt[j] != '0) && (cnt_nxt[j] != NEV);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state     <= IDLE;
      phase     <= '0;
      ecnt      <= '0;
      c_q       <= '0;
      mode_q    <= 1'b0;
      pat_q     <= '0;
      trig      <= 1'b0;
      ovalid    <= 1'b0;
      oresp     <= '0;
      ounstable <= '0;
      // NOTE: the vote counters are a small register array, not RAM, so resetting them is intended.
      for (int j = 0; j < K; j++) cnt[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ivalid) begin
            c_q    <= iC;
            mode_q <= imode;
            pat_q  <= ipattern;
            ecnt   <= '0;
            phase  <= '0;
            trig   <= 1'b0;
            for (int j = 0; j < K; j++) cnt[j] <= '0;
            state  <= DISCH;
          end
        end
        DISCH: begin
          if (phase == DIS_LAST) begin
            phase <= '0;
            trig  <= 1'b1;
            state <= CHARGE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CHARGE: begin
          if (phase == CHG_LAST) begin
            phase <= '0;
            state <= SAMPLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        SAMPLE: begin
          for (int j = 0; j < K; j++) cnt[j] <= cnt_nxt[j];
          ecnt <= ecnt + 1'b1;
          trig <= 1'b0;
          if (ecnt == ELAST) begin
            // Vote on the updated counts so the last sample is included.
            ovalid    <= 1'b1;
            oresp     <= resp_nxt;
            ounstable <= unst_nxt;
            state     <= DONE;
          end else begin
            state <= DISCH;
          end
        end
        DONE: begin
          if (iresp_ready) begin
            ovalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/puf_kline_eval.md
# puf_kline_eval

Parametrised K-line, N-stage multiplexer-permutation PUF core with an on-chip evaluation controller. It drives the trigger into the combinational delay network and samples the K line outputs after a programmable settle time. It repeats each evaluation NEVAL times and majority-votes every bit before returning a response, with per-bit instability flags. A self-test mode launches a known pattern through the network so that routing can be checked logically. The block is the next-generation replacement for the fixed 4-line/64-stage differential core and sits between the challenge source and the response post-processing.

## Interface
- K, 4: number of delay lines; power of two, at least 2.
- N, 64: number of stages; equals the challenge width.
- NEVAL, 3: evaluations per challenge; odd, at least 1.
- RST_CYC, 2: trigger-low (discharge) cycles per evaluation; at least 1.
- SETTLE_CYC, 4: trigger-high cycles before sampling; at least 1.
- iclk  in  1  clock.
- irst  in  1  reset, asynchronous, active-high.
- ivalid  in  1  challenge request.
- ordy  out  1  request accepted when ivalid && ordy.
- iC  in  N  challenge; bit s selects the permutation used by stage s.
- imode  in  1  0 = PUF launch, 1 = self-test launch.
- ipattern  in  K  self-test launch vector; ignored when imode = 0.
- ovalid  out  1  response valid.
- iresp_ready  in  1  response consumed when ovalid && iresp_ready.
- oresp  out  K  majority-voted response.
- ounstable  out  K  bit j = 1 if the samples of line j disagreed across evaluations.
- obusy  out  1  high in every state except IDLE.

## Operation
- Network (combinational; the stage hierarchy and nets are kept, not optimised):
  - The launch vector feeds the stage 0 input.
  - Launch vector is {K{trig}} when imode = 0, and ipattern & {K{trig}} when imode = 1.
  - Stage s output line i = in[(3i+s) mod K] if C[s] = 0, and in[(5i+s+1) mod K] if C[s] = 1.
  - Both index maps are bijections for K a power of two.
  - The stage N-1 output is the sampled line vector.
- On acceptance the block latches iC, imode and ipattern, clears the per-bit counters cnt[j] (width clog2(NEVAL+1)), and clears the evaluation counter.
- FSM:
  - IDLE: ordy = 1. On accept → DISCH.
  - DISCH: trig = 0 for RST_CYC cycles → CHARGE.
  - CHARGE: trig = 1 for SETTLE_CYC cycles → SAMPLE.
  - SAMPLE: 1 cycle. trig stays 1. At the closing edge, cnt[j] += line[j] and the evaluation counter increments. If this was evaluation NEVAL → DONE, else → DISCH.
  - DONE: trig = 0, ovalid = 1. oresp[j] = (cnt[j] > NEVAL/2). ounstable[j] = (cnt[j] != 0 && cnt[j] != NEVAL). On iresp_ready → IDLE.
- trig is a registered signal and is 0 in IDLE.
- oresp and ounstable are registered on entry to DONE and held stable while ovalid = 1.
- ivalid outside IDLE is ignored; no queueing.
- Reset (at any time, including mid-evaluation) forces:
  - state IDLE, trig 0;
  - ovalid 0, obusy 0;
  - oresp 0, ounstable 0;
  - all counters 0.
- ordy is 0 while irst is high and 1 in IDLE after release.

## Timing
- Accept at edge t. DISCH begins in cycle t+1.
- Each evaluation takes RST_CYC + SETTLE_CYC + 1 cycles.
- ovalid is first high at cycle t + 1 + NEVAL·(RST_CYC+SETTLE_CYC+1). With defaults this is t + 22.
- If iresp_ready is high in the first DONE cycle, ovalid lasts exactly 1 cycle.
- ordy returns in the cycle after the response handshake. Minimum back-to-back spacing is NEVAL·(RST+SETTLE+1) + 2 cycles.
- ivalid and iresp_ready are sampled on the same edge and are independent. A new request is not accepted in the handshake cycle.
- The counters cannot overflow: at most NEVAL increments per request.

## Test plan
- Reset mid-CHARGE with defaults: assert irst → on the same cycle trig = 0, ovalid = 0, obusy = 0. After release ordy = 1, and a new request completes normally.
- Self-test with K=4, N=64, iC = 0, ipattern = 4'b0001 → oresp = 4'b0001, ounstable = 0, ovalid at t+22.
- Self-test, ipattern = 4'b1111, random iC → oresp = 4'b1111. Random iC/ipattern pairs match the bench permutation model over 200 requests.
- PUF mode, any iC → oresp = 4'b1111 in zero-delay simulation, ounstable = 0. trig toggles exactly NEVAL times (3 rising edges).
- Backpressure: hold iresp_ready = 0 for 10 cycles → ovalid, oresp and ounstable hold constant, ordy stays 0, and ivalid pulses are ignored. Release → one handshake, then ordy = 1 next cycle.
- Instability: force line 2 to sample 1, 0, 1 across evaluations (bench force on the network output) → oresp[2] = 1, ounstable[2] = 1, other ounstable bits 0.
